ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx.sv | 197 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits LSB first,
// odd parity, stop bit, device ACK check, with a timeout guard.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned RTS_CYCLES     = 200,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic [1:0] tx_err
);

  localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int unsigned PW = (PHASE_MAX > 2) ? $clog2(PHASE_MAX) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

  localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] RTS_LAST = PW'(RTS_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic          nack_q, nack_d;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;
  logic          timing_state;

  // Pad synchronizers and ps2_clk deglitch filter state
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data_in;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Filter: accept a new clock level only after FILTER_LEN consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FLT_LAST) filt_d = clk_s2_q;
      else                    fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign fall = filt_q & ~filt_d;

  // Transfer FSM and registered line drivers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tout_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tout_q    <= tout_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      nack_q    <= nack_d;
    end
  end

  // Next-state logic; timeout is checked ahead of any clock-fall handling
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tout_d    = tout_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = err_q;
    nack_d    = nack_q;
    timing_state = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

    if (timing_state && (tout_q == TMO_LAST)) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      err_d     = 2'b10;
      done_d    = 1'b1;
      state_d   = S_DONE;
    end else begin
      if (timing_state) tout_d = tout_q + 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (tx_valid) begin
            shift_d  = {1'b1, ~^tx_data, tx_data};
            cnt_d    = '0;
            clk_oe_d = 1'b1;
            state_d  = S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            cnt_d     = '0;
            data_oe_d = 1'b1;
            state_d   = S_REQ;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_REQ: begin
          if (cnt_q == RTS_LAST) begin
            cnt_d    = '0;
            tout_d   = '0;
            bit_d    = '0;
            clk_oe_d = 1'b0;
            state_d  = S_SEND;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SEND: begin
          if (fall) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[9:1]};
            bit_d     = bit_q + 1'b1;
            if (bit_q == 4'd9) state_d = S_ACK;
          end
        end
        S_ACK: begin
          if (fall) begin
            nack_d  = dat_s2_q;
            state_d = S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (filt_q && dat_s2_q) begin
            err_d   = {1'b0, nack_q};
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host;
// expected completions are queued at stimulus time and checked on tx_done.
module tb_ps2_host_tx;

  localparam int unsigned INH = 100;
  localparam int unsigned RTS = 20;
  localparam int unsigned TMO = 5000;
  localparam int unsigned FL  = 4;
  localparam int          H   = 40;   // device half-period in clk cycles (scaled 12.5 kHz)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done;
  logic [1:0] tx_err;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk_lo = 1'b0, dev_data_lo = 1'b0, glitch_lo = 1'b0;
  logic [9:0] dev_frame = '0;

  // Open-drain bus: low whenever either side pulls
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_lo | glitch_lo);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_lo);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTS),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  typedef struct {
    logic [1:0]  err;
    bit          chk_frame;
    logic [9:0]  frame;
    bit          chk_lat;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_done(input logic [1:0] err, input bit cf, input logic [9:0] fr,
                             input bit cl, input int unsigned lat);
    exp_t e;
    e.err = err; e.chk_frame = cf; e.frame = fr; e.chk_lat = cl; e.lat = lat;
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every tx_done
  initial begin
    logic        prev_coe;
    logic        pend;
    int unsigned rel_cyc;
    exp_t        e;
    prev_coe = 1'b0;
    pend     = 1'b0;
    rel_cyc  = 0;
    forever begin
      @(negedge clk);
      if (prev_coe && !ps2_clk_oe) rel_cyc = cyc;
      prev_coe = ps2_clk_oe;
      if (pend) begin
        chk("done_one_cycle", 32'(tx_done), 32'(0));
        chk("ready_after_done", 32'(tx_ready), 32'(1));
        pend = 1'b0;
      end else if (tx_done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'(tx_done), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("tx_err", 32'(tx_err), 32'(e.err));
          chk("clk_oe_at_done", 32'(ps2_clk_oe), 32'(0));
          chk("data_oe_at_done", 32'(ps2_data_oe), 32'(0));
          if (e.chk_frame) chk("wire_frame", 32'(dev_frame), 32'(e.frame));
          if (e.chk_lat)   chk("timeout_latency", cyc - rel_cyc, e.lat);
          pend = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    while (!tx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device model: waits for request-to-send, clocks nbits and optionally the ACK
  task automatic dev_xfer(input int nbits, input bit ack, input bit glitch, input logic exp_oe);
    int t;
    logic [9:0] fr;
    t  = 0;
    fr = '0;
    while (!(ps2_data_oe && !ps2_clk_oe) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rts_seen", 32'(t < 2000), 32'(1));
    if (t >= 2000) return;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      dev_clk_lo = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_lo = 1'b0;
      fr[i] = ps2_data_in;
      if (glitch && i == 1) begin
        repeat (10) @(negedge clk);
        glitch_lo = 1'b1;
        repeat (2) @(negedge clk);
        glitch_lo = 1'b0;
        repeat (15) @(negedge clk);
        chk("oe_after_glitch", 32'(ps2_data_oe), 32'(exp_oe));
        repeat (H - 27) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    dev_frame = fr;
    if (nbits == 10) begin
      if (ack) dev_data_lo = 1'b1;
      repeat (H / 2) @(negedge clk);
      dev_clk_lo = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_lo = 1'b0;
      repeat (H) @(negedge clk);
      dev_data_lo = 1'b0;
    end
  endtask

  task automatic wait_sb(input int limit);
    int t;
    t = 0;
    while ((sb.size() != 0 || !tx_ready) && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk("completion_seen", 32'(t < limit), 32'(1));
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_ready", 32'(tx_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'(0));
    chk("rst_data_oe", 32'(ps2_data_oe), 32'(0));
    chk("rst_done", 32'(tx_done), 32'(0));
    chk("rst_err", 32'(tx_err), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // 0xF4: five ones -> parity 0
    expect_done(2'b00, 1'b1, 10'h2F4, 1'b0, 0);
    send(8'hF4);
    dev_xfer(10, 1'b1, 1'b0, 1'b0);
    wait_sb(3000);

    // 0xFF and 0x00: even weight -> parity 1
    expect_done(2'b00, 1'b1, 10'h3FF, 1'b0, 0);
    send(8'hFF);
    dev_xfer(10, 1'b1, 1'b0, 1'b0);
    wait_sb(3000);

    expect_done(2'b00, 1'b1, 10'h300, 1'b0, 0);
    send(8'h00);
    dev_xfer(10, 1'b1, 1'b0, 1'b0);
    wait_sb(3000);

    // Device leaves data high on the ACK clock
    expect_done(2'b01, 1'b1, 10'h3A5, 1'b0, 0);
    send(8'hA5);
    dev_xfer(10, 1'b0, 1'b0, 1'b0);
    wait_sb(3000);

    // Silent device: timeout exactly TMO cycles after clock release
    expect_done(2'b10, 1'b0, 10'h000, 1'b1, TMO);
    send(8'h3C);
    wait_sb(8000);

    // Reset after the 4th bit abandons the transfer
    send(8'hF4);
    dev_xfer(4, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_clk_oe", 32'(ps2_clk_oe), 32'(0));
    chk("abort_data_oe", 32'(ps2_data_oe), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(tx_done), 32'(0));
    chk("abort_err", 32'(tx_err), 32'(0));
    reset = 1'b0;
    repeat (20) @(negedge clk);

    expect_done(2'b00, 1'b1, 10'h2F4, 1'b0, 0);
    send(8'hF4);
    dev_xfer(10, 1'b1, 1'b0, 1'b0);
    wait_sb(3000);

    // Request while busy is dropped; a 2-cycle clock glitch must not advance the bit
    expect_done(2'b00, 1'b1, 10'h2F4, 1'b0, 0);
    send(8'hF4);
    repeat (30) @(negedge clk);
    chk("ready_while_busy", 32'(tx_ready), 32'(0));
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_xfer(10, 1'b1, 1'b1, 1'b1);
    wait_sb(3000);
    repeat (200) @(negedge clk);
    chk("no_second_transfer", 32'(busy), 32'(0));
    chk("idle_clk_oe", 32'(ps2_clk_oe), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
